// File: rtl/zigzag_varint_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_pkg
// Brief    : Shared types, constants and helpers for the zigzag varint encoder
// Revision : 1.0 - initial release
// ============================================================================
package zigzag_pkg;

   // Encoding mode as presented on in_mode
   typedef enum logic [1:0] {
      MODE_RAW  = 2'd0,
      MODE_ZZ32 = 2'd1,
      MODE_ZZ64 = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   // Encoder control states
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   // A 64-bit value never needs more than ten 7-bit groups
   localparam int MAX_VARINT_BYTES = 10;

   // Number of varint bytes needed for a value; zero still takes one byte
   function automatic logic [3:0] varint_len(input logic [63:0] value);
      logic [3:0] len;
      len = 4'd1;
      for (int i = 1; i < MAX_VARINT_BYTES; i++) begin
         if ((value >> (7 * i)) != 64'd0) begin
            len = 4'(i + 1);
         end
      end
      return len;
   endfunction

endpackage : zigzag_pkg
`default_nettype wire

// File: rtl/zigzag_varint_enc_if.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_varint_enc_if
// Brief    : Input-value and output-byte stream bundle of the varint encoder
// Revision : 1.0 - initial release
// ============================================================================
interface zigzag_varint_enc_if #(
   parameter int MAX_W = 64
);
   logic             en;
   logic             in_valid;
   logic             in_ready;
   logic [MAX_W-1:0] in_val;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_byte;
   logic             out_last;
   logic [3:0]       out_len;

   // Producer of values / consumer of bytes
   modport master (
      output en, in_valid, in_val, in_mode, out_ready,
      input  in_ready, out_valid, out_byte, out_last, out_len
   );

   // The encoder itself
   modport slave (
      input  en, in_valid, in_val, in_mode, out_ready,
      output in_ready, out_valid, out_byte, out_last, out_len
   );
endinterface : zigzag_varint_enc_if
`default_nettype wire

// File: rtl/zigzag_varint_enc_core.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_core
// Brief    : Combinational zigzag / raw transform selected by encoding mode
// Revision : 1.0 - initial release
// ============================================================================
module zigzag_core
   import zigzag_pkg::*;
#(
   parameter int MAX_W  = 64,
   parameter int EN_RAW = 1
) (
   input  logic [MAX_W-1:0] in_val,
   input  mode_e            mode,
   output logic [MAX_W-1:0] out_val
);

   mode_e            w_mode;
   logic [31:0]      w_zz32;
   logic [MAX_W-1:0] w_zz32_ext;
   logic [MAX_W-1:0] w_zz64;

   // 32-bit zigzag: shift left and flip all bits when the value is negative
   assign w_zz32 = {in_val[30:0], 1'b0} ^ {32{in_val[31]}};

   generate
      if (MAX_W == 64) begin : g_w64
         assign w_zz32_ext = {{(MAX_W-32){1'b0}}, w_zz32};
         assign w_zz64     = {in_val[MAX_W-2:0], 1'b0} ^ {MAX_W{in_val[MAX_W-1]}};
      end else begin : g_w32
         // Narrow build: 64-bit zigzag collapses onto the 32-bit one
         assign w_zz32_ext = w_zz32;
         assign w_zz64     = w_zz32;
      end
   endgenerate

   // Resolve reserved and disabled-raw modes onto a real transform
   always_comb begin
      w_mode = mode;
      if (w_mode == MODE_RSVD) begin
         w_mode = MODE_RAW;
      end
      if ((EN_RAW == 0) && (w_mode == MODE_RAW)) begin
         w_mode = (MAX_W == 32) ? MODE_ZZ32 : MODE_ZZ64;
      end
   end

   // Select the transformed value
   always_comb begin
      out_val = in_val;
      case (w_mode)
         MODE_ZZ32: out_val = w_zz32_ext;
         MODE_ZZ64: out_val = w_zz64;
         default:   out_val = in_val;
      endcase
   end

endmodule : zigzag_core
`default_nettype wire

// File: rtl/zigzag_varint_enc.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_varint_enc
// Brief    : Zigzag-transforms a value and streams it out as LEB128 varint
//            bytes, one per output handshake, with back-to-back support
// Revision : 1.0 - initial release
// ============================================================================
module zigzag_varint_enc
   import zigzag_pkg::*;
#(
   parameter int MAX_W  = 64,
   parameter int EN_RAW = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   zigzag_varint_enc_if.slave  bus
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [MAX_W-1:0] r_rem;
   logic [MAX_W-1:0] w_rem_nxt;
   logic [3:0]       r_len;
   logic [3:0]       w_len_nxt;
   logic [MAX_W-1:0] w_enc;
   logic             w_cont;
   logic             w_emit;
   logic             w_out_valid;
   logic             w_out_hs;
   logic             w_last_hs;
   logic             w_in_ready;
   logic             w_in_hs;

   zigzag_core #(
      .MAX_W  (MAX_W),
      .EN_RAW (EN_RAW)
   ) u_core (
      .in_val  (bus.in_val),
      .mode    (mode_e'(bus.in_mode)),
      .out_val (w_enc)
   );

   // More bytes follow while anything remains above the low 7 bits
   assign w_cont      = |r_rem[MAX_W-1:7];
   assign w_emit      = (r_state == ST_EMIT);
   assign w_out_valid = w_emit & bus.en;
   assign w_out_hs    = w_out_valid & bus.out_ready;
   assign w_last_hs   = w_out_hs & ~w_cont;
   // Reset gates in_ready directly so it is low for the whole reset pulse
   assign w_in_ready  = rst_n & bus.en & (~w_emit | w_last_hs);
   assign w_in_hs     = w_in_ready & bus.in_valid;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_byte  = w_emit ? {w_cont, r_rem[6:0]} : 8'h00;
   assign bus.out_last  = w_emit & ~w_cont;
   assign bus.out_len   = r_len;

   // Next state, remaining value and length; a new capture wins over the shift
   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_len_nxt   = r_len;
      if (w_in_hs) begin
         w_state_nxt = ST_EMIT;
         w_rem_nxt   = w_enc;
         w_len_nxt   = varint_len(64'(w_enc));
      end else if (w_out_hs) begin
         w_rem_nxt = r_rem >> 7;
         if (!w_cont) begin
            w_state_nxt = ST_IDLE;
         end
      end
   end

   // State, remaining-value shift register and length register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_rem   <= '0;
         r_len   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
         r_len   <= w_len_nxt;
      end
   end

endmodule : zigzag_varint_enc
`default_nettype wire

// File: tb/tb_zigzag_varint_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_zigzag_varint_enc
// Brief    : Directed, table-driven bench for zigzag_varint_enc
// Revision : 1.0 - initial release
// ============================================================================
module tb_zigzag_varint_enc;

   typedef struct {
      string       name;
      logic [63:0] val;
      logic [1:0]  mode;
      int          nbytes;
      logic [79:0] bytes;   // byte k at [8k +: 8]
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   zigzag_varint_enc_if #(.MAX_W(64)) bus ();

   zigzag_varint_enc #(
      .MAX_W  (64),
      .EN_RAW (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {out_valid, out_last, out_len, out_byte}
   function automatic logic [63:0] snap();
      return 64'({bus.out_valid, bus.out_last, bus.out_len, bus.out_byte});
   endfunction

   function automatic logic [63:0] exp_snap(input logic v, input logic l,
                                            input logic [3:0] n, input logic [7:0] b);
      return 64'({v, l, n, b});
   endfunction

   // Offer one value from idle and check every byte of its varint
   task automatic send(input string nm, input logic [63:0] v, input logic [1:0] m,
                       input int nb, input logic [79:0] bs);
      tick();
      bus.en = 1'b1; bus.in_valid = 1'b1; bus.in_val = v; bus.in_mode = m;
      bus.out_ready = 1'b1;
      #1 chk({nm, "/in_ready"}, 64'(bus.in_ready), 64'd1);
      tick();
      // Changing the inputs after capture must not affect the varint
      bus.in_valid = 1'b0; bus.in_val = ~v; bus.in_mode = ~m;
      for (int k = 0; k < nb; k++) begin
         #1 chk($sformatf("%s/byte%0d", nm, k), snap(),
                exp_snap(1'b1, k == nb - 1, 4'(nb), bs[8*k +: 8]));
         tick();
      end
      #1 chk({nm, "/done"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
   endtask

   vec_t vecs[13];

   initial begin
      n_chk = 0; n_pass = 0;
      vecs[0]  = '{"zz32_2",      64'd2,                  2'd1, 1,  80'h04};
      vecs[1]  = '{"zz32_m2",     64'hFFFF_FFFF_FFFF_FFFE, 2'd1, 1,  80'h03};
      vecs[2]  = '{"zz64_m2",     64'hFFFF_FFFF_FFFF_FFFE, 2'd2, 1,  80'h03};
      vecs[3]  = '{"zz32_min",    64'h0000_0000_8000_0000, 2'd1, 5,  80'h0F_FF_FF_FF_FF};
      vecs[4]  = '{"raw_300",     64'd300,                2'd0, 2,  80'h02_AC};
      vecs[5]  = '{"raw_ones",    64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 10, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF};
      vecs[6]  = '{"raw_0",       64'd0,                  2'd0, 1,  80'h00};
      vecs[7]  = '{"zz64_1",      64'd1,                  2'd2, 1,  80'h02};
      vecs[8]  = '{"rsvd_300",    64'd300,                2'd3, 2,  80'h02_AC};
      vecs[9]  = '{"zz32_hi_ign", 64'hDEAD_BEEF_0000_0001, 2'd1, 1,  80'h02};
      vecs[10] = '{"zz64_min",    64'h8000_0000_0000_0000, 2'd2, 10, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF};
      vecs[11] = '{"raw_128",     64'd128,                2'd0, 2,  80'h01_80};
      vecs[12] = '{"zz32_m1",     64'h0000_0000_FFFF_FFFF, 2'd1, 1,  80'h01};

      // Reset state
      rst_n = 1'b0;
      bus.en = 1'b1; bus.in_valid = 1'b0; bus.in_val = '0; bus.in_mode = 2'd0;
      bus.out_ready = 1'b1;
      #12;
      chk("reset/outputs", snap(), 64'd0);
      chk("reset/in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1 chk("release/in_ready", 64'(bus.in_ready), 64'd1);
      bus.en = 1'b0;
      #1 chk("en_low/in_ready", 64'(bus.in_ready), 64'd0);

      // Table of single varints
      for (int i = 0; i < 13; i++) begin
         send(vecs[i].name, vecs[i].val, vecs[i].mode, vecs[i].nbytes, vecs[i].bytes);
      end

      // Backpressure: first byte held for three stalled cycles
      tick();
      bus.en = 1'b1; bus.in_valid = 1'b1; bus.in_val = 64'd300; bus.in_mode = 2'd0;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0; bus.in_val = '0;
      for (int c = 0; c < 3; c++) begin
         #1 chk($sformatf("bp/hold%0d", c), snap(), exp_snap(1'b1, 1'b0, 4'd2, 8'hAC));
         tick();
      end
      bus.out_ready = 1'b1;
      #1 chk("bp/byte0", snap(), exp_snap(1'b1, 1'b0, 4'd2, 8'hAC));
      tick();
      #1 chk("bp/byte1", snap(), exp_snap(1'b1, 1'b1, 4'd2, 8'h02));
      tick();
      #1 chk("bp/done", 64'(bus.out_valid), 64'd0);

      // Enable drop during emission freezes and resumes on the same byte
      tick();
      bus.in_valid = 1'b1; bus.in_val = 64'd300; bus.in_mode = 2'd0;
      tick();
      bus.in_valid = 1'b0;
      #1 chk("en/byte0", snap(), exp_snap(1'b1, 1'b0, 4'd2, 8'hAC));
      tick();
      bus.en = 1'b0;
      #1 chk("en/frozen_a", 64'({bus.out_valid, bus.in_ready}), 64'b00);
      tick();
      #1 chk("en/frozen_b", 64'(bus.out_valid), 64'd0);
      tick();
      bus.en = 1'b1;
      #1 chk("en/resume", snap(), exp_snap(1'b1, 1'b1, 4'd2, 8'h02));
      tick();
      #1 chk("en/done", 64'(bus.out_valid), 64'd0);

      // Back-to-back: second value accepted with the last byte of the first
      tick();
      bus.in_valid = 1'b1; bus.in_val = 64'd1; bus.in_mode = 2'd2;
      tick();
      bus.in_val = 64'd2;
      #1 chk("b2b/first", snap(), exp_snap(1'b1, 1'b1, 4'd1, 8'h02));
      chk("b2b/in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      #1 chk("b2b/second", snap(), exp_snap(1'b1, 1'b1, 4'd1, 8'h04));
      tick();
      #1 chk("b2b/done", 64'(bus.out_valid), 64'd0);

      // Reset during the second byte discards the rest of the varint
      tick();
      bus.in_valid = 1'b1; bus.in_val = 64'd300; bus.in_mode = 2'd0;
      tick();
      bus.in_valid = 1'b0;
      tick();
      #1 chk("rst/byte1", snap(), exp_snap(1'b1, 1'b1, 4'd2, 8'h02));
      rst_n = 1'b0;
      #1 chk("rst/immediate", snap(), 64'd0);
      chk("rst/in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      rst_n = 1'b1;
      begin
         int seen;
         seen = 0;
         for (int c = 0; c < 4; c++) begin
            #1 if (bus.out_valid) seen++;
            tick();
         end
         chk("rst/no_partial", 64'(seen), 64'd0);
      end
      send("rst/zero", 64'd0, 2'd0, 1, 80'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Absolute time limit so the bench always terminates
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule : tb_zigzag_varint_enc
`default_nettype wire
